// File: rtl/change_pkg.sv
// Shared types and default denominations for the sequential change dispenser.
package change_pkg;

  typedef enum logic [1:0] {
    COIN_Q    = 2'd0,
    COIN_D    = 2'd1,
    COIN_N    = 2'd2,
    COIN_NONE = 2'd3
  } coin_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PLAN     = 2'd1,
    DISPENSE = 2'd2,
    DONE     = 2'd3
  } state_t;

  localparam int DEF_QUARTER = 32'd25;
  localparam int DEF_DIME    = 32'd10;
  localparam int DEF_NICKEL  = 32'd5;

endpackage

// File: rtl/change_dispenser_seq_coin_inventory.sv
// Three saturating coin inventory counters with refill-add and dispense-decrement.
// Built only when COIN_INVENTORY_EN is defined.
`ifdef COIN_INVENTORY_EN
module coin_inventory
  import change_pkg::*;
#(
  parameter int COUNT_W    = 5,
  parameter int INIT_COUNT = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               refill_en,
  input  coin_t              refill_coin,
  input  logic [COUNT_W-1:0] refill_count,
  input  logic               dec_en,
  input  coin_t              dec_coin,
  output logic [COUNT_W-1:0] inv_q,
  output logic [COUNT_W-1:0] inv_d,
  output logic [COUNT_W-1:0] inv_n
);

  localparam logic [COUNT_W-1:0] INIT_V   = COUNT_W'(INIT_COUNT);
  localparam logic [COUNT_W-1:0] CNT_ZERO = {COUNT_W{1'b0}};
  localparam logic [COUNT_W-1:0] CNT_ONE  = {{(COUNT_W-1){1'b0}}, 1'b1};

  function automatic logic [COUNT_W-1:0] sat_add(input logic [COUNT_W-1:0] a,
                                                 input logic [COUNT_W-1:0] b);
    logic [COUNT_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[COUNT_W] ? {COUNT_W{1'b1}} : sum[COUNT_W-1:0];
  endfunction

  // Refill and dispense never overlap (IDLE vs DISPENSE); decrement is floored at zero.
  function automatic logic [COUNT_W-1:0] next_count(input logic [COUNT_W-1:0] cur,
                                                    input logic               add,
                                                    input logic [COUNT_W-1:0] amount,
                                                    input logic               sub);
    if (add) begin
      return sat_add(cur, amount);
    end else if (sub && (cur != CNT_ZERO)) begin
      return cur - CNT_ONE;
    end else begin
      return cur;
    end
  endfunction

  // Inventory registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      inv_q <= INIT_V;
      inv_d <= INIT_V;
      inv_n <= INIT_V;
    end else begin
      inv_q <= next_count(inv_q, refill_en && (refill_coin == COIN_Q), refill_count,
                          dec_en && (dec_coin == COIN_Q));
      inv_d <= next_count(inv_d, refill_en && (refill_coin == COIN_D), refill_count,
                          dec_en && (dec_coin == COIN_D));
      inv_n <= next_count(inv_n, refill_en && (refill_coin == COIN_N), refill_count,
                          dec_en && (dec_coin == COIN_N));
    end
  end

endmodule
`endif

// File: rtl/change_dispenser_seq.sv
// Greedy quarter/dime/nickel change planner and one-coin-per-cycle dispenser.
// Finite inventory and refill path are enabled by COIN_INVENTORY_EN; otherwise supply is unlimited.
module change_dispenser_seq
  import change_pkg::*;
#(
  parameter int CHANGE_W   = 9,
  parameter int COUNT_W    = 5,
  parameter int QUARTER    = DEF_QUARTER,
  parameter int DIME       = DEF_DIME,
  parameter int NICKEL     = DEF_NICKEL,
  parameter int INIT_COUNT = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [CHANGE_W-1:0] req_change,
  input  logic                refill_valid,
  input  logic [1:0]          refill_coin,
  input  logic [COUNT_W-1:0]  refill_count,
  output logic                coin_valid,
  output logic [1:0]          coin_type,
  output logic                done,
  output logic                done_ok,
  output logic [COUNT_W-1:0]  quarters,
  output logic [COUNT_W-1:0]  dimes,
  output logic [COUNT_W-1:0]  nickels,
  output logic [COUNT_W-1:0]  inv_q,
  output logic [COUNT_W-1:0]  inv_d,
  output logic [COUNT_W-1:0]  inv_n
);

  typedef struct packed {
    logic [COUNT_W-1:0] q;
    logic [COUNT_W-1:0] d;
    logic [COUNT_W-1:0] n;
  } cnt3_t;

  localparam logic [COUNT_W-1:0]  CNT_ZERO  = {COUNT_W{1'b0}};
  localparam logic [COUNT_W-1:0]  CNT_ONE   = {{(COUNT_W-1){1'b0}}, 1'b1};
  localparam logic [COUNT_W-1:0]  CNT_MAX   = {COUNT_W{1'b1}};
  localparam cnt3_t               CNT3_ZERO = '{q: CNT_ZERO, d: CNT_ZERO, n: CNT_ZERO};
  localparam logic [CHANGE_W-1:0] REM_ZERO  = {CHANGE_W{1'b0}};
  localparam logic [CHANGE_W-1:0] Q_VAL     = CHANGE_W'(QUARTER);
  localparam logic [CHANGE_W-1:0] D_VAL     = CHANGE_W'(DIME);
  localparam logic [CHANGE_W-1:0] N_VAL     = CHANGE_W'(NICKEL);

  state_t              state_r, state_s;
  logic [CHANGE_W-1:0] rem_r, rem_s;
  cnt3_t               plan_r, plan_s;
  cnt3_t               left_r, left_s;
  cnt3_t               result_r, result_s;
  logic                ok_r, ok_s;
  logic                q_avail_s, d_avail_s, n_avail_s;
  coin_t               pick_s;
  logic [COUNT_W-1:0]  pick_cnt_s;
  coin_t               disp_type_s;

`ifdef COIN_INVENTORY_EN
  coin_inventory #(
    .COUNT_W   (COUNT_W),
    .INIT_COUNT(INIT_COUNT)
  ) u_inventory (
    .clk         (clk),
    .rst         (rst),
    .refill_en   (refill_valid && (state_r == IDLE)),
    .refill_coin (coin_t'(refill_coin)),
    .refill_count(refill_count),
    .dec_en      (state_r == DISPENSE),
    .dec_coin    (disp_type_s),
    .inv_q       (inv_q),
    .inv_d       (inv_d),
    .inv_n       (inv_n)
  );

  assign q_avail_s = (plan_r.q < inv_q);
  assign d_avail_s = (plan_r.d < inv_d);
  assign n_avail_s = (plan_r.n < inv_n);
`else
  logic unused_refill_s;

  assign unused_refill_s = ^{refill_valid, refill_coin, refill_count};
  assign inv_q     = CNT_MAX;
  assign inv_d     = CNT_MAX;
  assign inv_n     = CNT_MAX;
  assign q_avail_s = 1'b1;
  assign d_avail_s = 1'b1;
  assign n_avail_s = 1'b1;
`endif

  // Greedy selection: the largest coin that still fits the remainder and is available.
  always_comb begin
    if ((rem_r >= Q_VAL) && q_avail_s) begin
      pick_s     = COIN_Q;
      pick_cnt_s = plan_r.q;
    end else if ((rem_r >= D_VAL) && d_avail_s) begin
      pick_s     = COIN_D;
      pick_cnt_s = plan_r.d;
    end else if ((rem_r >= N_VAL) && n_avail_s) begin
      pick_s     = COIN_N;
      pick_cnt_s = plan_r.n;
    end else begin
      pick_s     = COIN_NONE;
      pick_cnt_s = CNT_ZERO;
    end
  end

  // Dispense order: all quarters, then dimes, then nickels.
  always_comb begin
    if (left_r.q != CNT_ZERO) begin
      disp_type_s = COIN_Q;
    end else if (left_r.d != CNT_ZERO) begin
      disp_type_s = COIN_D;
    end else begin
      disp_type_s = COIN_N;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_s  = state_r;
    rem_s    = rem_r;
    plan_s   = plan_r;
    left_s   = left_r;
    result_s = result_r;
    ok_s     = ok_r;
    case (state_r)
      IDLE: begin
        if (req_valid) begin
          rem_s   = req_change;
          plan_s  = CNT3_ZERO;
          state_s = PLAN;
        end else begin
          state_s = IDLE;
        end
      end
      PLAN: begin
        if (pick_s == COIN_NONE) begin
          if (rem_r == REM_ZERO) begin
            result_s = plan_r;
            left_s   = plan_r;
            ok_s     = 1'b1;
            state_s  = (plan_r == CNT3_ZERO) ? DONE : DISPENSE;
          end else begin
            result_s = CNT3_ZERO;
            ok_s     = 1'b0;
            state_s  = DONE;
          end
        end else if (pick_cnt_s == CNT_MAX) begin
          result_s = CNT3_ZERO;
          ok_s     = 1'b0;
          state_s  = DONE;
        end else begin
          case (pick_s)
            COIN_Q: begin
              plan_s.q = plan_r.q + CNT_ONE;
              rem_s    = rem_r - Q_VAL;
            end
            COIN_D: begin
              plan_s.d = plan_r.d + CNT_ONE;
              rem_s    = rem_r - D_VAL;
            end
            COIN_N: begin
              plan_s.n = plan_r.n + CNT_ONE;
              rem_s    = rem_r - N_VAL;
            end
            default: begin
              state_s = DONE;
            end
          endcase
        end
      end
      DISPENSE: begin
        case (disp_type_s)
          COIN_Q:  left_s.q = left_r.q - CNT_ONE;
          COIN_D:  left_s.d = left_r.d - CNT_ONE;
          default: left_s.n = left_r.n - CNT_ONE;
        endcase
        if (left_s == CNT3_ZERO) begin
          state_s = DONE;
        end else begin
          state_s = DISPENSE;
        end
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= IDLE;
      rem_r    <= REM_ZERO;
      plan_r   <= CNT3_ZERO;
      left_r   <= CNT3_ZERO;
      result_r <= CNT3_ZERO;
      ok_r     <= 1'b0;
    end else begin
      state_r  <= state_s;
      rem_r    <= rem_s;
      plan_r   <= plan_s;
      left_r   <= left_s;
      result_r <= result_s;
      ok_r     <= ok_s;
    end
  end

  assign req_ready  = (state_r == IDLE);
  assign coin_valid = (state_r == DISPENSE);
  assign coin_type  = (state_r == DISPENSE) ? disp_type_s : COIN_NONE;
  assign done       = (state_r == DONE);
  assign done_ok    = ok_r;
  assign quarters   = result_r.q;
  assign dimes      = result_r.d;
  assign nickels    = result_r.n;

endmodule

// File: tb/tb_change_dispenser_seq.sv
// Scoreboard bench for change_dispenser_seq: directed scenarios plus randomized requests
// checked against an arithmetic greedy model.
module tb_change_dispenser_seq;
  import change_pkg::*;

  localparam int CHANGE_W = 9;
  localparam int COUNT_W  = 5;
  localparam int QV       = 25;
  localparam int DV       = 10;
  localparam int NV       = 5;
  localparam int INIT     = 0;
  localparam int MAXC     = 31;
`ifdef COIN_INVENTORY_EN
  localparam bit INV_EN = 1'b1;
`else
  localparam bit INV_EN = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                rst;
  logic                req_valid;
  logic                req_ready;
  logic [CHANGE_W-1:0] req_change;
  logic                refill_valid;
  logic [1:0]          refill_coin;
  logic [COUNT_W-1:0]  refill_count;
  logic                coin_valid;
  logic [1:0]          coin_type;
  logic                done;
  logic                done_ok;
  logic [COUNT_W-1:0]  quarters, dimes, nickels;
  logic [COUNT_W-1:0]  inv_q, inv_d, inv_n;

  change_dispenser_seq #(
    .CHANGE_W(CHANGE_W), .COUNT_W(COUNT_W), .QUARTER(QV), .DIME(DV), .NICKEL(NV),
    .INIT_COUNT(INIT)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_change(req_change),
    .refill_valid(refill_valid), .refill_coin(refill_coin), .refill_count(refill_count),
    .coin_valid(coin_valid), .coin_type(coin_type),
    .done(done), .done_ok(done_ok),
    .quarters(quarters), .dimes(dimes), .nickels(nickels),
    .inv_q(inv_q), .inv_d(inv_d), .inv_n(inv_n)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit ok;
    int q, d, n;
    int iq, id, inn;
    int cyc;
  } exp_t;

  exp_t exp_q[$];
  int   coin_q[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   mq, md, mn;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string name, int act, int expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
    end
  endfunction

  function automatic int sat(int v);
    return (v > MAXC) ? MAXC : v;
  endfunction

  // Greedy split from the rules: as many of each coin as fit and are available.
  function automatic void plan_model(input int amt, input int aq, input int ad, input int an,
                                     output bit ok, output int q, output int d, output int n,
                                     output int j);
    int val[3];
    int cap[3];
    int take[3];
    int rem;
    val  = '{QV, DV, NV};
    cap  = INV_EN ? '{aq, ad, an} : '{MAXC, MAXC, MAXC};
    take = '{0, 0, 0};
    rem  = amt;
    ok   = 1'b1;
    j    = 0;
    for (int i = 0; i < 3; i++) begin
      if (ok) begin
        take[i] = rem / val[i];
        if (take[i] > cap[i]) take[i] = cap[i];
        rem -= take[i] * val[i];
        j   += take[i];
        if (!INV_EN && rem >= val[i]) ok = 1'b0;
      end
    end
    if (rem != 0) ok = 1'b0;
    q = ok ? take[0] : 0;
    d = ok ? take[1] : 0;
    n = ok ? take[2] : 0;
  endfunction

  task automatic model_refill(input int rcoin, input int rcnt);
    if (INV_EN) begin
      case (rcoin)
        0:       mq = sat(mq + rcnt);
        1:       md = sat(md + rcnt);
        2:       mn = sat(mn + rcnt);
        default: ;
      endcase
    end
  endtask

  task automatic do_refill(input int rcoin, input int rcnt);
    refill_valid = 1'b1;
    refill_coin  = 2'(rcoin);
    refill_count = COUNT_W'(rcnt);
    model_refill(rcoin, rcnt);
    @(posedge clk);
    #1;
    refill_valid = 1'b0;
  endtask

  task automatic start_req(input int amt, input bit with_refill, input int rcoin, input int rcnt);
    exp_t e;
    bit   ok;
    int   q, d, n, j, lat;
    chk("req_ready_idle", int'(req_ready), 1);
    req_valid  = 1'b1;
    req_change = CHANGE_W'(amt);
    if (with_refill) begin
      refill_valid = 1'b1;
      refill_coin  = 2'(rcoin);
      refill_count = COUNT_W'(rcnt);
      model_refill(rcoin, rcnt);
    end
    plan_model(amt, mq, md, mn, ok, q, d, n, j);
    if (ok) begin
      mq -= q;
      md -= d;
      mn -= n;
      for (int i = 0; i < q; i++) coin_q.push_back(0);
      for (int i = 0; i < d; i++) coin_q.push_back(1);
      for (int i = 0; i < n; i++) coin_q.push_back(2);
    end
    lat   = ok ? (2 * (q + d + n) + 1) : (j + 1);
    e.ok  = ok;
    e.q   = q;
    e.d   = d;
    e.n   = n;
    e.iq  = INV_EN ? mq : MAXC;
    e.id  = INV_EN ? md : MAXC;
    e.inn = INV_EN ? mn : MAXC;
    @(posedge clk);
    #1;
    e.cyc = cyc + lat;
    exp_q.push_back(e);
    req_valid    = 1'b0;
    refill_valid = 1'b0;
  endtask

  task automatic wait_done();
    for (int t = 0; t < 300 && exp_q.size() != 0; t++) @(posedge clk);
    #1;
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL done_timeout: got no done, expected done within 300 cycles");
      exp_q.delete();
      coin_q.delete();
    end
    chk("coins_left_unemitted", coin_q.size(), 0);
    coin_q.delete();
  endtask

  task automatic do_req(input int amt, input bit with_refill, input int rcoin, input int rcnt,
                        input bit busy_refill);
    start_req(amt, with_refill, rcoin, rcnt);
    if (busy_refill) begin
      repeat (3) @(posedge clk);
      #1;
      refill_valid = 1'b1;
      refill_coin  = 2'd2;
      refill_count = 5'd5;
      @(posedge clk);
      #1;
      refill_valid = 1'b0;
    end
    wait_done();
  endtask

  task automatic check_reset();
    chk("rst_req_ready", int'(req_ready), 1);
    chk("rst_coin_valid", int'(coin_valid), 0);
    chk("rst_coin_type", int'(coin_type), 3);
    chk("rst_done", int'(done), 0);
    chk("rst_done_ok", int'(done_ok), 0);
    chk("rst_counts", int'(quarters) + int'(dimes) + int'(nickels), 0);
    chk("rst_inv_q", int'(inv_q), INV_EN ? INIT : MAXC);
    chk("rst_inv_d", int'(inv_d), INV_EN ? INIT : MAXC);
    chk("rst_inv_n", int'(inv_n), INV_EN ? INIT : MAXC);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    coin_q.delete();
    mq = INIT;
    md = INIT;
    mn = INIT;
  endtask

  // Monitor: pops expected coins and request results as the DUT presents them.
  always @(negedge clk) begin
    exp_t e;
    int   ec;
    if (!rst) begin
      if (coin_valid) begin
        if (coin_q.size() == 0) begin
          chk("unexpected_coin", int'(coin_type), 3);
        end else begin
          ec = coin_q.pop_front();
          chk("coin_type", int'(coin_type), ec);
        end
      end else begin
        chk("idle_coin_type", int'(coin_type), 3);
      end
      if (done) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", int'(done), 0);
        end else begin
          e = exp_q.pop_front();
          chk("done_cycle", cyc, e.cyc);
          chk("done_ok", int'(done_ok), int'(e.ok));
          chk("quarters", int'(quarters), e.q);
          chk("dimes", int'(dimes), e.d);
          chk("nickels", int'(nickels), e.n);
          chk("inv_q", int'(inv_q), e.iq);
          chk("inv_d", int'(inv_d), e.id);
          chk("inv_n", int'(inv_n), e.inn);
          chk("busy_req_ready", int'(req_ready), 0);
        end
      end
    end
  end

  initial begin
    int amt;
    bit found;
    rst          = 1'b1;
    req_valid    = 1'b0;
    req_change   = '0;
    refill_valid = 1'b0;
    refill_coin  = 2'd0;
    refill_count = '0;
    mq = INIT;
    md = INIT;
    mn = INIT;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_reset();
    @(posedge clk);
    #1;

    do_refill(0, 10);
    do_refill(1, 10);
    do_refill(2, 10);
    do_req(65, 1'b0, 0, 0, 1'b0);
    do_req(0, 1'b0, 0, 0, 1'b0);
    do_req(42, 1'b0, 0, 0, 1'b0);

    // Greedy dead end: one quarter, no nickels for the 5-cent residue.
    pulse_reset();
    do_refill(0, 1);
    do_refill(1, 3);
    do_req(30, 1'b0, 0, 0, 1'b0);

    // Reset in the second dispense cycle of a 65-cent request.
    do_refill(0, 10);
    do_refill(1, 10);
    do_refill(2, 10);
    start_req(65, 1'b0, 0, 0);
    found = 1'b0;
    for (int t = 0; t < 50 && !found; t++) begin
      @(negedge clk);
      found = coin_valid;
    end
    chk("first_coin_seen", int'(found), 1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    coin_q.delete();
    mq = INIT;
    md = INIT;
    mn = INIT;
    @(negedge clk);
    check_reset();
    @(posedge clk);
    #1;

    // Refill together with the request, then a refill while busy that must be dropped.
    do_req(10, 1'b1, 2, 2, 1'b1);
    do_req(5, 1'b0, 0, 0, 1'b0);

    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 2) == 0) do_refill(int'($urandom_range(0, 3)), int'($urandom_range(0, 31)));
      if ($urandom_range(0, 3) == 0) amt = int'($urandom_range(0, 511));
      else amt = int'($urandom_range(0, 150));
      if ($urandom_range(0, 1) == 1) amt = amt - (amt % 5);
      do_req(amt, ($urandom_range(0, 3) == 0), int'($urandom_range(0, 3)),
             int'($urandom_range(0, 31)), 1'b0);
    end

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
